demux_stream_1xn: RTL and testbench
===================================

// Module: demux_stream_1xn
// PURPOSE
//  Parametrised, registered 1-to-N stream demultiplexer with valid/ready flow control.
//  Routes each accepted input word to one channel selected by S, or to all channels in broadcast mode.
//  Each output channel has its own one-entry holding register, so a stalled channel never blocks words bound for other channels.
//  Sits between a single producer and up to N independent consumers.
// PARAMETERS
//  WIDTH  8   data width of Din and of each Y channel, >=1
//  N      8   number of output channels, 2..64; need not be a power of two
//  SEL_W  3   width of S; must be >= clog2(N)
// PORTS
//  clk       in   1          single clock; all logic on the rising edge
//  rst_n     in   1          reset, asynchronous assert, active-low
//  Din       in   WIDTH      input data word
//  S         in   SEL_W      channel select for the current Din
//  Bcast     in   1          1 = broadcast Din to all N channels; S ignored
//  Din_valid in   1          producer has a word on Din/S/Bcast
//  Din_ready out  1          block accepts the word this cycle
//  Y         out  N*WIDTH    channel i data = Y[i*WIDTH +: WIDTH]
//  Y_valid   out  N          channel i holds a word
//  Y_ready   in   N          consumer i takes its word this cycle
//  Drop      out  1          1-cycle pulse: a word was accepted with S>=N and discarded
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): Y=0, Y_valid=0, Drop=0. Din_ready is combinational and is 0 while rst_n=0.
//  Channel i is free when ~Y_valid[i] | Y_ready[i], i.e. it is empty or is being drained this cycle.
//  Din_ready (combinational, never depends on Din_valid):
//   - Bcast=1: AND of free over all N channels.
//   - Bcast=0, S<N: free[S].
//   - Bcast=0, S>=N: 1.
//  Accept = Din_valid & Din_ready. Producer must hold Din, S and Bcast stable while Din_valid=1 and Din_ready=0.
//  On accept, routed mode (S<N): next cycle Y[S]=Din and Y_valid[S]=1. Latency is 1 cycle.
//  On accept, broadcast mode: next cycle every channel loads Din and every Y_valid bit is 1.
//  On accept with Bcast=0 and S>=N: no channel changes; Drop=1 for exactly the next cycle.
//  Drain: Y_valid[i] & Y_ready[i] with no new load into i: next cycle Y_valid[i]=0, and Y[i] holds its old value.
//  Drain and load on the same channel in the same cycle: the new word replaces the old one and Y_valid[i] stays 1.
//   This gives 1 word/cycle sustained per channel.
//  Channels not addressed by the current accept keep their data and valid state.
//   A Y_ready[i] on an empty channel has no effect.
//  Y[i] changes only on a load into channel i. It is stable while Y_valid[i]=1 and Y_ready[i]=0.
//  Broadcast is all-or-nothing: no channel loads until every channel is free. No partial fan-out.
//  Y_ready may be asserted with Y_valid=0; the block tolerates this.
//  rst_n asserted mid-transfer: all held words are lost and Y_valid clears immediately (asynchronously).
//   The first accept is possible in the first clock after rst_n releases.
//  No combinational path from Y_ready to Y or Y_valid. The combinational path Y_ready -> Din_ready is allowed.
// TESTING
//  1. Reset: hold rst_n=0 mid-run with Y_valid=8'hFF -> Y_valid=0 and Y=0 immediately, Din_ready=0 while rst_n=0.
//  2. Routed: WIDTH=8, N=8, Y_ready=8'hFF, send Din=8'hA5 S=3 then Din=8'h5A S=3 back-to-back
//     -> Y_valid[3]=1 one cycle after each accept, Y[3]=A5 then 5A, Din_ready stays 1, no other channel valid.
//  3. Backpressure: Y_ready[2]=0, send S=2 twice -> first word is held in channel 2, Din_ready=0 for the second;
//     meanwhile S=5 is still accepted. Raise Y_ready[2] -> second word loads the same cycle the first drains.
//  4. Broadcast: Bcast=1, Din=8'h3C, Y_ready=8'hFE with Y_valid[0]=1 -> Din_ready=0.
//     Set Y_ready[0]=1 -> accept; next cycle Y_valid=8'hFF and every channel reads 3C.
//  5. Drop: N=6, SEL_W=3, send S=7 Din=8'h11 -> Din_ready=1, Drop pulses 1 cycle, Y_valid is unchanged.
//  6. Random: random Din_valid/S/Bcast/Y_ready over 10k cycles -> scoreboard per channel shows
//     no loss, no duplication, in-order delivery, and Y stable while stalled.

Source files
------------

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N valid/ready stream demultiplexer.
// Each channel has a one-entry holding register. Broadcast mode loads every channel at once.
module demux_stream_1xn #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   Din,
  input  logic [SEL_W-1:0]   S,
  input  logic               Bcast,
  input  logic               Din_valid,
  output logic               Din_ready,
  output logic [N*WIDTH-1:0] Y,
  output logic [N-1:0]       Y_valid,
  input  logic [N-1:0]       Y_ready,
  output logic               Drop
);

  logic [N-1:0][WIDTH-1:0] y_r;
  logic [N-1:0]            y_valid_r;
  logic                    drop_r;

  logic [N-1:0]            free_s;
  logic [N-1:0]            sel_s;
  logic [N-1:0]            load_s;
  logic                    in_range_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    drop_s;

  // Channel free flags and one-hot decode of S; an out-of-range S decodes to all zeros
  always_comb begin
    free_s = ~y_valid_r | Y_ready;
    sel_s  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (S == SEL_W'(i)) begin
        sel_s[i] = 1'b1;
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Handshake and per-channel load decision
  always_comb begin
    in_range_s = |sel_s;
    ready_s    = 1'b0;
    load_s     = {N{1'b0}};
    drop_s     = 1'b0;
    if (!rst_n) begin
      ready_s = 1'b0;
    end else if (Bcast) begin
      ready_s = &free_s;
    end else if (in_range_s) begin
      ready_s = |(sel_s & free_s);
    end else begin
      ready_s = 1'b1;
    end
    accept_s = Din_valid & ready_s;
    if (!accept_s) begin
      load_s = {N{1'b0}};
      drop_s = 1'b0;
    end else if (Bcast) begin
      load_s = {N{1'b1}};
      drop_s = 1'b0;
    end else begin
      load_s = sel_s;
      drop_s = ~in_range_s;
    end
  end

  // Holding registers: a load wins over a drain, so a channel can sustain one word per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= {(N*WIDTH){1'b0}};
      y_valid_r <= {N{1'b0}};
      drop_r    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load_s[i]) begin
          y_r[i]       <= Din;
          y_valid_r[i] <= 1'b1;
        end else if (Y_ready[i]) begin
          y_valid_r[i] <= 1'b0;
        end else begin
          y_valid_r[i] <= y_valid_r[i];
        end
      end
      drop_r <= drop_s;
    end
  end

  assign Din_ready = ready_s;
  assign Y         = y_r;
  assign Y_valid   = y_valid_r;
  assign Drop      = drop_r;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Self-checking bench for demux_stream_1xn: per-channel expected-word queues,
// directed routed/backpressure/broadcast/reset/drop cases, then a random run.
module tb_demux_stream_1xn;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic [2:0]  s;
  logic        bcast;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] y;
  logic [7:0]  y_valid;
  logic [7:0]  y_ready;
  logic        drop;

  logic [7:0]  d6_din;
  logic [2:0]  d6_s;
  logic        d6_bcast;
  logic        d6_valid;
  logic        d6_ready;
  logic [47:0] d6_y;
  logic [5:0]  d6_y_valid;
  logic [5:0]  d6_y_ready;
  logic        d6_drop;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q [8][$];
  logic       exp_drop;

  demux_stream_1xn #(.WIDTH(8), .N(8), .SEL_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .Din(din), .S(s), .Bcast(bcast),
    .Din_valid(din_valid), .Din_ready(din_ready), .Y(y), .Y_valid(y_valid),
    .Y_ready(y_ready), .Drop(drop)
  );

  demux_stream_1xn #(.WIDTH(8), .N(6), .SEL_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .Din(d6_din), .S(d6_s), .Bcast(d6_bcast),
    .Din_valid(d6_valid), .Din_ready(d6_ready), .Y(d6_y), .Y_valid(d6_y_valid),
    .Y_ready(d6_y_ready), .Drop(d6_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    exp_drop = 1'b0;
  endtask

  // One cycle: drive at posedge+1, check at negedge against the queues, advance model, cross posedge.
  task automatic step(input logic dv, input logic [7:0] d, input logic [2:0] sel,
                      input logic bc, input logic [7:0] yr, output logic acc, output logic rdy_seen);
    logic [7:0] vbits;
    logic       exp_rdy;
    din_valid = dv; din = d; s = sel; bcast = bc; y_ready = yr;
    @(negedge clk);
    for (int i = 0; i < 8; i++) vbits[i] = (exp_q[i].size() != 0);
    check("drop", drop, exp_drop);
    check("y_valid", y_valid, vbits);
    for (int i = 0; i < 8; i++)
      if (vbits[i]) check($sformatf("y_data[%0d]", i), y[i*8 +: 8], exp_q[i][0]);
    exp_rdy = bc ? &(~vbits | yr) : (~vbits[sel] | yr[sel]);
    check("din_ready", din_ready, exp_rdy);
    rdy_seen = din_ready;
    for (int i = 0; i < 8; i++)
      if (vbits[i] && yr[i]) void'(exp_q[i].pop_front());
    acc = dv & exp_rdy;
    exp_drop = 1'b0;
    if (acc) begin
      if (bc) begin
        for (int i = 0; i < 8; i++) exp_q[i].push_back(d);
      end else begin
        exp_q[sel].push_back(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic       acc;
  logic       rdy;
  logic       pend;
  logic [7:0] rd;
  logic [2:0] rs;
  logic       rb;

  initial begin
    rst_n = 1'b0;
    din = 8'h00; s = 3'd0; bcast = 1'b0; din_valid = 1'b1; y_ready = 8'h00;
    d6_din = 8'h00; d6_s = 3'd0; d6_bcast = 1'b0; d6_valid = 1'b0; d6_y_ready = 6'h00;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", din_ready, 1'b0);
    check("rst_valid", y_valid, 8'h00);
    check("rst_y", y, 64'h0);
    check("rst_drop", drop, 1'b0);
    rst_n = 1'b1;

    // Routed back-to-back on channel 3, all consumers ready
    step(1'b1, 8'hA5, 3'd3, 1'b0, 8'hFF, acc, rdy);
    check("t2_rdy1", rdy, 1'b1);
    check("t2_v1", y_valid, 8'h08);
    check("t2_y1", y[31:24], 8'hA5);
    step(1'b1, 8'h5A, 3'd3, 1'b0, 8'hFF, acc, rdy);
    check("t2_rdy2", rdy, 1'b1);
    check("t2_v2", y_valid, 8'h08);
    check("t2_y2", y[31:24], 8'h5A);
    step(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, acc, rdy);

    // Backpressure on channel 2 while channel 5 keeps flowing
    step(1'b1, 8'h21, 3'd2, 1'b0, 8'hFB, acc, rdy);
    step(1'b1, 8'h22, 3'd2, 1'b0, 8'hFB, acc, rdy);
    check("t3_blocked", rdy, 1'b0);
    step(1'b1, 8'h55, 3'd5, 1'b0, 8'hFB, acc, rdy);
    check("t3_other", rdy, 1'b1);
    check("t3_hold", y[23:16], 8'h21);
    step(1'b1, 8'h22, 3'd2, 1'b0, 8'hFF, acc, rdy);
    check("t3_swap_rdy", rdy, 1'b1);
    check("t3_swap_v", y_valid[2], 1'b1);
    check("t3_swap_y", y[23:16], 8'h22);
    step(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, acc, rdy);

    // Broadcast waits for every channel to be free
    step(1'b1, 8'h01, 3'd0, 1'b0, 8'hFF, acc, rdy);
    step(1'b1, 8'h3C, 3'd0, 1'b1, 8'hFE, acc, rdy);
    check("t4_blocked", rdy, 1'b0);
    step(1'b1, 8'h3C, 3'd0, 1'b1, 8'hFF, acc, rdy);
    check("t4_rdy", rdy, 1'b1);
    check("t4_valid", y_valid, 8'hFF);
    check("t4_y", y, {8{8'h3C}});
    step(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, acc, rdy);

    // Asynchronous reset with every channel full
    din_valid = 1'b1; s = 3'd0; bcast = 1'b0; y_ready = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid", y_valid, 8'h00);
    check("t1_y", y, 64'h0);
    check("t1_ready", din_ready, 1'b0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'h77, 3'd6, 1'b0, 8'h00, acc, rdy);
    check("t1_first_acc", rdy, 1'b1);
    check("t1_first_v", y_valid, 8'h40);
    step(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, acc, rdy);

    // Random traffic; a pending word is held stable until accepted
    pend = 1'b0; rd = 8'h00; rs = 3'd0; rb = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        rd = 8'($urandom);
        rs = 3'($urandom_range(0, 7));
        rb = ($urandom_range(0, 9) == 0);
      end
      step(pend, rd, rs, rb, 8'($urandom), acc, rdy);
      if (acc) pend = 1'b0;
    end
    step(1'b0, 8'h00, 3'd0, 1'b0, 8'hFF, acc, rdy);
    din_valid = 1'b0;

    // Out-of-range select on a six-channel instance
    d6_valid = 1'b1; d6_s = 3'd7; d6_din = 8'h11; d6_y_ready = 6'h00;
    @(negedge clk);
    check("t5_ready", d6_ready, 1'b1);
    check("t5_drop0", d6_drop, 1'b0);
    @(posedge clk);
    #1;
    d6_valid = 1'b0;
    check("t5_drop", d6_drop, 1'b1);
    check("t5_valid", d6_y_valid, 6'h00);
    @(posedge clk);
    #1;
    check("t5_drop_end", d6_drop, 1'b0);
    d6_valid = 1'b1; d6_s = 3'd5; d6_din = 8'h99;
    @(posedge clk);
    #1;
    check("t5_route_v", d6_y_valid, 6'h20);
    check("t5_route_y", d6_y[47:40], 8'h99);
    check("t5_route_drop", d6_drop, 1'b0);
    d6_s = 3'd6; d6_din = 8'h66;
    @(negedge clk);
    check("t5_s6_ready", d6_ready, 1'b1);
    @(posedge clk);
    #1;
    d6_valid = 1'b0;
    check("t5_s6_drop", d6_drop, 1'b1);
    check("t5_s6_valid", d6_y_valid, 6'h20);
    check("t5_s6_y", d6_y[47:40], 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
